// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the iterative right shifter.
package shift_pkg;

  localparam int unsigned SHIFT_WIDTH = 32;
  localparam int unsigned SHIFT_AMT_W = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;

endpackage

// File: rtl/shift_right_step.sv
// One power-of-two stage of a right shifter: shifts by 2^i_stage, filling
// vacated upper bits with i_fill, or passes data through when disabled.
module shift_right_step
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = SHIFT_WIDTH,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_stage,
  input  logic             i_fill,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_data_c
);

  logic [AMT_W-1:0] w_dist;
  logic [WIDTH-1:0] w_fill_mask;

  // 2^stage never exceeds WIDTH/2, so it fits in AMT_W bits.
  assign w_dist      = AMT_W'(1) << i_stage;
  assign w_fill_mask = ~({WIDTH{1'b1}} >> w_dist);

  assign o_data_c = i_enable ? ((i_data >> w_dist) | (i_fill ? w_fill_mask : '0))
                             : i_data;

endmodule

// File: rtl/seq_shift_right.sv
// Iterative logical/arithmetic right shifter, one power-of-two stage per clock.
// Define SEQ_SHIFT_SKIP_EN to visit only the set bits of the shift amount.
module seq_shift_right
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = SHIFT_WIDTH,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  shift_state_t     r_state;
  shift_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_out;
  logic [AMT_W-1:0] r_amt;
  logic             r_fill;
  logic             w_accept;
  logic             w_last;
  logic             w_step_en;
  logic [AMT_W-1:0] w_step_idx;
  logic [WIDTH-1:0] w_step;

  assign w_accept = in_valid && in_ready;
  assign out_data = r_out;

`ifdef SEQ_SHIFT_SKIP_EN
  // Stage selection: lowest remaining set bit of the amount.
  always_comb begin
    w_step_idx = '0;
    for (int i = int'(AMT_W) - 1; i >= 0; i--) begin
      if (r_amt[i]) w_step_idx = AMT_W'(i);
    end
  end

  assign w_step_en = (r_amt != '0);
  assign w_last    = ((r_amt & (r_amt - AMT_W'(1))) == '0);
`else
  logic [AMT_W-1:0] r_stage;

  assign w_step_idx = r_stage;
  assign w_step_en  = r_amt[r_stage];
  assign w_last     = (r_stage == AMT_W'(AMT_W - 1));
`endif

  shift_right_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_data   (r_data),
    .i_stage  (w_step_idx),
    .i_fill   (r_fill),
    .i_enable (w_step_en),
    .o_data_c (w_step)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
`ifdef SEQ_SHIFT_SKIP_EN
          w_state_nxt = (in_amount == '0) ? DONE : SHIFT;
`else
          w_state_nxt = SHIFT;
`endif
        end
      end
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Datapath: capture operands at accept, step in SHIFT, latch result on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_out   <= '0;
      r_amt   <= '0;
      r_fill  <= 1'b0;
`ifndef SEQ_SHIFT_SKIP_EN
      r_stage <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data <= in_data;
            r_amt  <= in_amount;
            r_fill <= in_arith & in_data[WIDTH-1];
`ifdef SEQ_SHIFT_SKIP_EN
            if (in_amount == '0) r_out <= in_data;
`else
            r_stage <= '0;
`endif
          end
        end
        SHIFT: begin
          r_data <= w_step;
`ifdef SEQ_SHIFT_SKIP_EN
          r_amt <= r_amt & (r_amt - AMT_W'(1));
`else
          r_stage <= r_stage + AMT_W'(1);
`endif
          if (w_last) r_out <= w_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_right.sv
// Directed, table-driven bench for seq_shift_right (WIDTH=32).
module tb_seq_shift_right;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amount;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  amt;
    logic        arith;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  seq_shift_right #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_arith  (in_arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Edges after the accept edge until out_valid is seen.
  function automatic int exp_lat(input logic [4:0] a);
`ifdef SEQ_SHIFT_SKIP_EN
    int n = 0;
    for (int b = 0; b < 5; b++) n += int'(a[b]);
    return n;
`else
    return 5;
`endif
  endfunction

  // Called #1 after a rising edge; returns with out_valid high (or timeout).
  task automatic run_req(input logic [31:0] d, input logic [4:0] a, input logic ar,
                         output int lat);
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = a;
    in_arith  = ar;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = 32'h5A5A_0F0F;
    in_amount = 5'h1F;
    in_arith  = ~ar;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amount = '0;
    in_arith  = 1'b0;
    out_ready = 1'b1;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    vecs[0]  = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
    vecs[1]  = '{32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000};
    vecs[2]  = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000};
    vecs[3]  = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678};
    vecs[4]  = '{32'hFFFF_0000, 5'd16, 1'b0, 32'h0000_FFFF};
    vecs[5]  = '{32'hFFFF_0000, 5'd17, 1'b0, 32'h0000_7FFF};
    vecs[6]  = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[7]  = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000};
    vecs[8]  = '{32'hDEAD_BEEF, 5'd8,  1'b1, 32'hFFDE_ADBE};
    vecs[9]  = '{32'h1234_5678, 5'd12, 1'b1, 32'h0001_2345};
    vecs[10] = '{32'hA5A5_A5A5, 5'd1,  1'b0, 32'h52D2_D2D2};
    vecs[11] = '{32'hA5A5_A5A5, 5'd3,  1'b1, 32'hF4B4_B4B4};

    for (int i = 0; i < 12; i++) begin
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      run_req(vecs[i].data, vecs[i].amt, vecs[i].arith, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].amt)));
      check($sformatf("v%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("v%0d_busy", i), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result held, new request refused.
    out_ready = 1'b0;
    run_req(32'hA5A5_A5A5, 5'd3, 1'b1, lat);
    check("bp_data", out_data, 32'hF4B4_B4B4);
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    in_amount = 5'd0;
    in_arith  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_data", c), out_data, 32'hF4B4_B4B4);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_hold_idle_data", out_data, 32'hF4B4_B4B4);
    @(posedge clk); #1;
    check("bp_no_ghost_req", 32'(in_ready), 32'd1);

    // Reset two edges after accept aborts without emitting a result.
    in_valid  = 1'b1;
    in_data   = 32'h0F0F_0F0F;
    in_amount = 5'd3;
    in_arith  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_data", out_data, 32'h0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mrst_no_partial", 32'(out_valid), 32'd0);
    run_req(32'hFFFF_0000, 5'd16, 1'b0, lat);
    check("mrst_after_latency", 32'(lat), 32'(exp_lat(5'd16)));
    check("mrst_after_data", out_data, 32'h0000_FFFF);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
